hazard_forward_unit: RTL and testbench

Parametrised forwarding and load-use hazard unit for the 5-stage RISC-V pipeline. Selects per-operand ALU forwarding sources independently. Detects load-use hazards between ID and EX, and holds a configurable-length stall through a small FSM. Optionally counts stall cycles for performance analysis. Sits beside the ID/EX pipeline register; its outputs drive the ALU operand muxes, the PC/IF-ID enables, and the ID/EX bubble insert.

---
 rtl/hazard_forward_unit.sv | 183 ++++++++++++++++++
 tb/tb_hazard_forward_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_unit.sv
// ---------------------------------------------------------------------------
// hazard_forward_unit
//
// Forwarding and load-use hazard unit for the 5-stage RISC-V pipeline.
//
// - ALU operand forwarding is purely combinational. Each operand is decided
//   on its own: MEM has priority over WB, and x0 is never forwarded.
// - A load in EX whose destination feeds the instruction in ID raises a
//   load-use hazard. The unit then holds stall/flush_ex high for LOAD_LAT
//   cycles. A two-state FSM (IDLE/HOLD) sequences the stall.
// - When HFU_STALL_CNT_EN is defined, a saturating counter records the
//   number of cycles with stall=1. When it is undefined, stall_count is
//   tied to zero and no counter flops are built.
//
// Parameters:
//   ADDR_W   register address width
//   LOAD_LAT bubble cycles per load-use hazard (1..15)
//   CNT_W    width of the stall performance counter
//
// Ports:
//   clk, arst_n                  clock, asynchronous active-low reset
//   rs1_id, rs2_id               sources of the instruction in ID
//   rs1_ex, rs2_ex, rd_ex        sources/destination of the instruction in EX
//   mem_read_ex, reg_write_ex    EX instruction is a load / writes rd
//   rd_mem, reg_write_mem        MEM destination and write enable
//   rd_wb, reg_write_wb          WB destination and write enable
//   flush_id                     instruction in ID is being squashed
//   mux_alu_1, mux_alu_2         operand source: 00 regfile, 01 WB, 10 MEM
//   stall                        freeze PC and IF/ID
//   flush_ex                     insert a bubble into ID/EX
//   stall_count                  saturating count of stall cycles
// ---------------------------------------------------------------------------
module hazard_forward_unit #(
    parameter int ADDR_W   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic [ADDR_W-1:0] rs1_id,
    input  logic [ADDR_W-1:0] rs2_id,
    input  logic [ADDR_W-1:0] rs1_ex,
    input  logic [ADDR_W-1:0] rs2_ex,
    input  logic [ADDR_W-1:0] rd_ex,
    input  logic              mem_read_ex,
    input  logic              reg_write_ex,
    input  logic [ADDR_W-1:0] rd_mem,
    input  logic              reg_write_mem,
    input  logic [ADDR_W-1:0] rd_wb,
    input  logic              reg_write_wb,
    input  logic              flush_id,
    output logic [1:0]        mux_alu_1,
    output logic [1:0]        mux_alu_2,
    output logic              stall,
    output logic              flush_ex,
    output logic [CNT_W-1:0]  stall_count
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Number of stall cycles that remain after the hazard cycle itself.
    localparam logic [3:0] HOLD_LEN = 4'(LOAD_LAT - 1);

    state_t      state_q, state_d;
    logic [3:0]  remain_q, remain_d;
    logic        hazard;
    logic        stall_o;
    logic        mem_fwd_1, mem_fwd_2, wb_fwd_1, wb_fwd_2;

    // Forwarding match terms. A write to x0 never forwards.
    always_comb begin
        mem_fwd_1 = reg_write_mem && (rd_mem != '0) && (rd_mem == rs1_ex);
        mem_fwd_2 = reg_write_mem && (rd_mem != '0) && (rd_mem == rs2_ex);
        wb_fwd_1  = reg_write_wb  && (rd_wb  != '0) && (rd_wb  == rs1_ex);
        wb_fwd_2  = reg_write_wb  && (rd_wb  != '0) && (rd_wb  == rs2_ex);
    end

    // Operand source select. MEM holds the younger result, so it wins over WB.
    always_comb begin
        mux_alu_1 = 2'b00;
        mux_alu_2 = 2'b00;
        if (mem_fwd_1) begin
            mux_alu_1 = 2'b10;
        end else if (wb_fwd_1) begin
            mux_alu_1 = 2'b01;
        end
        if (mem_fwd_2) begin
            mux_alu_2 = 2'b10;
        end else if (wb_fwd_2) begin
            mux_alu_2 = 2'b01;
        end
    end

    // A squashed ID instruction can never cause a load-use hazard.
    always_comb begin
        hazard = mem_read_ex && reg_write_ex && (rd_ex != '0) &&
                 ((rd_ex == rs1_id) || (rd_ex == rs2_id)) && !flush_id;
    end

    // State register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q  <= IDLE;
            remain_q <= '0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
        end
    end

    // Next-state logic. New hazards are evaluated only in IDLE. A flush in
    // HOLD abandons the remaining stall cycles.
    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        unique case (state_q)
            IDLE: begin
                if (hazard && (LOAD_LAT > 1)) begin
                    state_d  = HOLD;
                    remain_d = HOLD_LEN;
                end
            end
            HOLD: begin
                if (flush_id || (remain_q <= 4'd1)) begin
                    state_d  = IDLE;
                    remain_d = '0;
                end else begin
                    remain_d = remain_q - 4'd1;
                end
            end
            default: begin
                state_d  = IDLE;
                remain_d = '0;
            end
        endcase
    end

    // Output logic. Reset gates the outputs combinationally, so a stall
    // stops the moment reset asserts. This holds even when a hazard is
    // present on the inputs.
    always_comb begin
        stall_o = 1'b0;
        unique case (state_q)
            IDLE:    stall_o = hazard;
            HOLD:    stall_o = !flush_id;
            default: stall_o = 1'b0;
        endcase
        if (!arst_n) begin
            stall_o = 1'b0;
        end
    end

    assign stall    = stall_o;
    assign flush_ex = stall_o;

`ifdef HFU_STALL_CNT_EN
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    // Saturating stall-cycle counter.
    always_comb begin
        stall_count_d = stall_count_q;
        if (stall_o && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_forward_unit
//
// Drives two instances of hazard_forward_unit from the same inputs:
//   - dut_a: LOAD_LAT=1, CNT_W=16
//   - dut_b: LOAD_LAT=3, CNT_W=4 (small counter so saturation is reachable)
//
// Reference model:
//   - Each stall window is tracked as an absolute end cycle.
//   - The counter is tracked as an integer clamped to its maximum value.
// ---------------------------------------------------------------------------
module tb_hazard_forward_unit;

    logic       clk = 1'b0;
    logic       arst_n;
    logic [4:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
    logic       mem_read_ex, reg_write_ex, reg_write_mem, reg_write_wb, flush_id;

    logic [1:0]  mux1_a, mux2_a, mux1_b, mux2_b;
    logic        stall_a, flush_ex_a, stall_b, flush_ex_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;

    int checks = 0;
    int errors = 0;

    // Model state: cycle index, end of the current stall window (exclusive),
    // and the counter value for each instance.
    int cyc = 0;
    int hold_end[2] = '{0, 0};
    int cnt_model[2] = '{0, 0};
    int lat[2] = '{1, 3};
    int cnt_max[2] = '{65535, 15};

    always #5 clk = ~clk;

    hazard_forward_unit #(.ADDR_W(5), .LOAD_LAT(1), .CNT_W(16)) dut_a (
        .clk(clk), .arst_n(arst_n),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex),
        .rd_ex(rd_ex), .mem_read_ex(mem_read_ex), .reg_write_ex(reg_write_ex),
        .rd_mem(rd_mem), .reg_write_mem(reg_write_mem),
        .rd_wb(rd_wb), .reg_write_wb(reg_write_wb), .flush_id(flush_id),
        .mux_alu_1(mux1_a), .mux_alu_2(mux2_a),
        .stall(stall_a), .flush_ex(flush_ex_a), .stall_count(cnt_a)
    );

    hazard_forward_unit #(.ADDR_W(5), .LOAD_LAT(3), .CNT_W(4)) dut_b (
        .clk(clk), .arst_n(arst_n),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex),
        .rd_ex(rd_ex), .mem_read_ex(mem_read_ex), .reg_write_ex(reg_write_ex),
        .rd_mem(rd_mem), .reg_write_mem(reg_write_mem),
        .rd_wb(rd_wb), .reg_write_wb(reg_write_wb), .flush_id(flush_id),
        .mux_alu_1(mux1_b), .mux_alu_2(mux2_b),
        .stall(stall_b), .flush_ex(flush_ex_b), .stall_count(cnt_b)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Forwarding source for one operand: 2 = MEM, 1 = WB, 0 = regfile.
    function automatic int fwdSource(input logic [4:0] rs);
        if (reg_write_mem && rd_mem != 0 && rd_mem == rs) return 2;
        if (reg_write_wb && rd_wb != 0 && rd_wb == rs) return 1;
        return 0;
    endfunction

    // Drive one cycle of inputs, check all outputs against the model,
    // then advance the model to the state after the next rising edge.
    task automatic applyStimulus(
        input logic rstn,
        input logic [4:0] r1id, input logic [4:0] r2id,
        input logic [4:0] r1ex, input logic [4:0] r2ex,
        input logic [4:0] rdex, input logic mr, input logic rwex,
        input logic [4:0] rdm, input logic rwm,
        input logic [4:0] rdw, input logic rww,
        input logic fl);
        bit haz;
        bit exp_stall[2];
        @(negedge clk);
        arst_n = rstn;
        rs1_id = r1id; rs2_id = r2id; rs1_ex = r1ex; rs2_ex = r2ex;
        rd_ex = rdex; mem_read_ex = mr; reg_write_ex = rwex;
        rd_mem = rdm; reg_write_mem = rwm; rd_wb = rdw; reg_write_wb = rww;
        flush_id = fl;
        #1;
        haz = mr && rwex && (rdex != 0) && (rdex == r1id || rdex == r2id) && !fl;
        for (int k = 0; k < 2; k++) begin
            if (!rstn) begin
                exp_stall[k] = 1'b0;
                hold_end[k]  = 0;
                cnt_model[k] = 0;
            end else if (cyc < hold_end[k]) begin
                exp_stall[k] = !fl;
                if (fl) hold_end[k] = cyc + 1;
            end else begin
                exp_stall[k] = haz;
                if (haz) hold_end[k] = cyc + lat[k];
            end
        end
        checkOutput("mux1_a", mux1_a, fwdSource(r1ex));
        checkOutput("mux2_a", mux2_a, fwdSource(r2ex));
        checkOutput("mux1_b", mux1_b, fwdSource(r1ex));
        checkOutput("mux2_b", mux2_b, fwdSource(r2ex));
        checkOutput("stall_a", stall_a, exp_stall[0]);
        checkOutput("flush_ex_a", flush_ex_a, exp_stall[0]);
        checkOutput("stall_b", stall_b, exp_stall[1]);
        checkOutput("flush_ex_b", flush_ex_b, exp_stall[1]);
        checkOutput("cnt_a", cnt_a, cnt_model[0]);
        checkOutput("cnt_b", cnt_b, cnt_model[1]);
`ifdef HFU_STALL_CNT_EN
        for (int k = 0; k < 2; k++) begin
            if (exp_stall[k] && cnt_model[k] < cnt_max[k]) cnt_model[k]++;
        end
`endif
        cyc++;
    endtask

    task automatic quietCycle();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        arst_n = 0;
        {rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb} = '0;
        {mem_read_ex, reg_write_ex, reg_write_mem, reg_write_wb, flush_id} = '0;

        // Reset with a hazard present on the inputs: outputs must stay low.
        applyStimulus(0, 0, 7, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("reset_stall", stall_b, 0);
        checkOutput("reset_cnt", cnt_b, 0);

        // Forwarding independence and MEM priority.
        applyStimulus(1, 0, 0, 5, 6, 0, 0, 0, 5, 1, 6, 1, 0);
        checkOutput("fwd_indep_1", mux1_a, 2'b10);
        checkOutput("fwd_indep_2", mux2_a, 2'b01);
        applyStimulus(1, 0, 0, 5, 6, 0, 0, 0, 5, 1, 5, 1, 0);
        checkOutput("fwd_mem_prio", mux1_a, 2'b10);

        // x0 suppression on forwarding and on load-use.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        checkOutput("x0_fwd_1", mux1_a, 2'b00);
        checkOutput("x0_fwd_2", mux2_a, 2'b00);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        checkOutput("x0_load", stall_a, 0);

        // Load-use: dut_a stalls one cycle, dut_b three. The hazard is
        // toggled during dut_b's HOLD.
        applyStimulus(1, 0, 7, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0);
        checkOutput("lu_T_a", stall_a, 1);
        checkOutput("lu_T_b", stall_b, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("lu_T1_a", stall_a, 0);
        checkOutput("lu_T1_b", stall_b, 1);
        applyStimulus(1, 9, 0, 0, 0, 9, 1, 1, 0, 0, 0, 0, 0);
        checkOutput("lu_T2_b", stall_b, 1);
        quietCycle();
        checkOutput("lu_T3_b", stall_b, 0);
        quietCycle();

        // flush_id abort during HOLD.
        applyStimulus(1, 3, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0);
        applyStimulus(1, 3, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0, 1);
        checkOutput("flush_T1_b", stall_b, 0);
        quietCycle();
        checkOutput("flush_T2_b", stall_b, 0);

        // flush_id coincident with a hazard in IDLE.
        applyStimulus(1, 3, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0, 1);
        checkOutput("flush_idle_b", stall_b, 0);

        // Reset asserted mid-HOLD.
        applyStimulus(1, 4, 0, 0, 0, 4, 1, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rst_hold_stall", stall_b, 0);
        checkOutput("rst_hold_cnt", cnt_b, 0);
        quietCycle();
        checkOutput("rst_release_b", stall_b, 0);

        // Twenty consecutive stall cycles saturate the 4-bit counter.
        for (int i = 0; i < 20; i++) applyStimulus(1, 8, 0, 0, 0, 8, 1, 1, 0, 0, 0, 0, 0);
        quietCycle();
`ifdef HFU_STALL_CNT_EN
        checkOutput("cnt_saturate", cnt_b, 15);
`else
        checkOutput("cnt_tied_zero", cnt_b, 0);
`endif

        // Randomized traffic over a small register range to provoke matches.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 99) != 0),
                          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                          5'($urandom_range(0, 3)), 1'($urandom),
                          5'($urandom_range(0, 3)), 1'($urandom),
                          ($urandom_range(0, 7) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
